// File: rtl/i2s_stereo_framer.sv
// i2s_stereo_framer
//  Pairs 24-bit mono samples from the I2S receiver into {left,right} stereo
//  frames and buffers them in a DEPTH-entry first-word-fall-through FIFO.
//  Frames leave through a valid/ready handshake. Channel-order slips and
//  dropped frames are reported through sticky flags.
// Ports
//  clk_i, rst_i          clock, asynchronous active-high reset
//  enable_i              0 holds the pairing FSM in WAIT_LEFT; the pop side keeps draining
//  clear_i               synchronous flush of FIFO, flags and FSM
//  sample_i/lr_i         mono sample and its channel tag (0=left, 1=right)
//  sample_valid_i        single-cycle strobe qualifying sample_i/lr_i
//  m_valid_o/m_ready_i   consumer handshake; a frame is taken when both are 1
//  m_left_o/m_right_o    head frame (registered)
//  level_o               number of frames stored (0..DEPTH)
//  overflow_o            sticky: a completed frame was dropped because the FIFO was full
//  sync_err_o            sticky: left-left or orphan-right sequence seen
module i2s_stereo_framer #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [DATA_W-1:0]        sample_i,
    input  logic                     sample_valid_i,
    input  logic                     lr_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [DATA_W-1:0]        m_left_o,
    output logic [DATA_W-1:0]        m_right_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic                     sync_err_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned FRAME_W = 2 * DATA_W;

    typedef enum logic {
        S_WAIT_LEFT  = 1'b0,
        S_WAIT_RIGHT = 1'b1
    } state_t;

    state_t               r_state;
    logic [DATA_W-1:0]    r_left_hold;
    logic                 r_sync_err;

    logic [FRAME_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 r_valid;
    logic [FRAME_W-1:0]   r_head;
    logic                 r_overflow;

    logic                 w_strobe;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [PTR_W-1:0]     w_rd_next;
    logic [LVL_W-1:0]     w_level_next;
    logic [FRAME_W-1:0]   w_frame;
    logic [FRAME_W-1:0]   w_head_next;

    // Qualified sample strobe; clear_i and enable_i=0 block any pairing activity
    assign w_strobe   = sample_valid_i & enable_i & ~clear_i;
    assign w_push_req = w_strobe & (r_state == S_WAIT_RIGHT) & lr_i;
    assign w_pop      = r_valid & m_ready_i & ~clear_i;
    assign w_full     = (r_level == LVL_W'(DEPTH));
    // A full FIFO still accepts a frame when the head leaves in the same cycle
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_frame    = {r_left_hold, sample_i};
    assign w_rd_next  = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    // Next head: the frame being written bypasses storage when it lands in the head slot
    assign w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? w_frame : r_mem[w_rd_next];

    // Pairing FSM with orphan/duplicate-left detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_WAIT_LEFT;
            r_left_hold <= '0;
            r_sync_err  <= 1'b0;
        end else if (clear_i) begin
            r_state     <= S_WAIT_LEFT;
            r_sync_err  <= 1'b0;
        end else if (!enable_i) begin
            r_state     <= S_WAIT_LEFT;
        end else if (sample_valid_i) begin
            case (r_state)
                S_WAIT_LEFT: begin
                    if (!lr_i) begin
                        r_left_hold <= sample_i;
                        r_state     <= S_WAIT_RIGHT;
                    end else begin
                        r_sync_err  <= 1'b1;
                    end
                end
                S_WAIT_RIGHT: begin
                    if (lr_i) begin
                        r_state     <= S_WAIT_LEFT;
                    end else begin
                        r_left_hold <= sample_i;
                        r_sync_err  <= 1'b1;
                    end
                end
                default: r_state <= S_WAIT_LEFT;
            endcase
        end
    end

    // Frame storage; contents are only meaningful below r_level, so no reset needed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_frame;
        end
    end

    // Pointers, occupancy, registered FWFT head and overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            r_valid  <= (w_level_next != '0);
            // Head holds its last value once the FIFO runs empty
            if (w_level_next != '0) begin
                r_head <= w_head_next;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign m_valid_o  = r_valid;
    assign m_left_o   = r_head[FRAME_W-1:DATA_W];
    assign m_right_o  = r_head[DATA_W-1:0];
    assign level_o    = r_level;
    assign overflow_o = r_overflow;
    assign sync_err_o = r_sync_err;

endmodule

// File: tb/tb_i2s_stereo_framer.sv
// Bench for i2s_stereo_framer: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_i2s_stereo_framer;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              lr;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_left;
    logic [DATA_W-1:0] m_right;
    logic [3:0]        level;
    logic              overflow;
    logic              sync_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2s_stereo_framer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .clear_i        (clear),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .lr_i           (lr),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_left_o       (m_left),
        .m_right_o      (m_right),
        .level_o        (level),
        .overflow_o     (overflow),
        .sync_err_o     (sync_err)
    );

    typedef struct {
        logic        sv;
        logic        lr;
        logic [23:0] s;
        logic        rdy;
        logic        en;
        logic        clr;
        logic        ev;
        logic [23:0] el;
        logic [23:0] er;
        logic [3:0]  elv;
        logic        es;
        logic        eo;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    // Reference model state
    logic [47:0] mq [$];
    logic        m_pend;
    logic [23:0] m_hold;
    logic        m_sync;
    logic        m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic l, input logic [23:0] s,
                         input logic rdy, input logic en, input logic clr);
        sample_valid = sv;
        lr           = l;
        sample       = s;
        m_ready      = rdy;
        enable       = en;
        clear        = clr;
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input logic rdy);
        drive(1'b1, 1'b0, l, rdy, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b1, r, rdy, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 24'h0, rdy, 1'b1, 1'b0);
    endtask

    function automatic vec_t mk(input logic sv, input logic l, input logic [23:0] s,
                                input logic rdy, input logic en, input logic clr,
                                input logic ev, input logic [23:0] el, input logic [23:0] er,
                                input logic [3:0] elv, input logic es, input logic eo);
        vec_t v;
        v.sv = sv; v.lr = l; v.s = s; v.rdy = rdy; v.en = en; v.clr = clr;
        v.ev = ev; v.el = el; v.er = er; v.elv = elv; v.es = es; v.eo = eo;
        return v;
    endfunction

    function automatic logic [23:0] fl(input int k);
        return 24'h100000 + 24'(k);
    endfunction

    function automatic logic [23:0] fr(input int k);
        return 24'h200000 + 24'(k);
    endfunction

    // One cycle of the reference model, using the inputs about to be clocked in
    task automatic model_cycle(input logic sv, input logic l, input logic [23:0] s,
                               input logic rdy, input logic en, input logic clr);
        if (clr) begin
            mq.delete();
            m_pend = 1'b0;
            m_sync = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (!en) begin
                m_pend = 1'b0;
            end else if (sv) begin
                if (!l) begin
                    if (m_pend) m_sync = 1'b1;
                    m_pend = 1'b1;
                    m_hold = s;
                end else if (!m_pend) begin
                    m_sync = 1'b1;
                end else begin
                    m_pend = 1'b0;
                    if (mq.size() < int'(DEPTH)) mq.push_back({m_hold, s});
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    initial begin
        // Table: T1 basic pair, T3 order slips, clear, enable gating
        vecs[0]  = mk(0,0,24'h000000,1,1,0, 0,24'h0,24'h0,           0,0,0);
        vecs[1]  = mk(1,0,24'h123456,1,1,0, 0,24'h0,24'h0,           0,0,0);
        vecs[2]  = mk(1,1,24'hABCDEF,1,1,0, 1,24'h123456,24'hABCDEF, 1,0,0);
        vecs[3]  = mk(0,0,24'h000000,1,1,0, 0,24'h0,24'h0,           0,0,0);
        vecs[4]  = mk(1,1,24'h111111,1,1,0, 0,24'h0,24'h0,           0,1,0);
        vecs[5]  = mk(1,0,24'h222222,1,1,0, 0,24'h0,24'h0,           0,1,0);
        vecs[6]  = mk(1,0,24'h333333,1,1,0, 0,24'h0,24'h0,           0,1,0);
        vecs[7]  = mk(1,1,24'h444444,0,1,0, 1,24'h333333,24'h444444, 1,1,0);
        vecs[8]  = mk(0,0,24'h000000,0,1,0, 1,24'h333333,24'h444444, 1,1,0);
        vecs[9]  = mk(0,0,24'h000000,1,1,0, 0,24'h0,24'h0,           0,1,0);
        vecs[10] = mk(0,0,24'h000000,1,1,1, 0,24'h0,24'h0,           0,0,0);
        vecs[11] = mk(1,0,24'h555555,1,1,0, 0,24'h0,24'h0,           0,0,0);
        vecs[12] = mk(0,0,24'h000000,1,0,0, 0,24'h0,24'h0,           0,0,0);
        vecs[13] = mk(1,1,24'h666666,1,1,0, 0,24'h0,24'h0,           0,1,0);
        vecs[14] = mk(1,0,24'h777777,1,0,0, 0,24'h0,24'h0,           0,1,0);
        vecs[15] = mk(1,1,24'h888888,1,1,0, 0,24'h0,24'h0,           0,1,0);

        rst = 1'b1;
        drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(m_valid), 64'(0));
        check("reset_level", 64'(level), 64'(0));
        check("reset_left", 64'(m_left), 64'(0));
        check("reset_right", 64'(m_right), 64'(0));
        check("reset_ovf", 64'(overflow), 64'(0));
        check("reset_sync", 64'(sync_err), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].sv, vecs[i].lr, vecs[i].s, vecs[i].rdy, vecs[i].en, vecs[i].clr);
            step();
            check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].elv));
            check($sformatf("vec%0d_sync", i), 64'(sync_err), 64'(vecs[i].es));
            check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].eo));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_left", i), 64'(m_left), 64'(vecs[i].el));
                check($sformatf("vec%0d_right", i), 64'(m_right), 64'(vecs[i].er));
            end
        end

        // Fill to full, push-with-pop at full, then overflow, then drain in order
        drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        step();
        check("clr_sync", 64'(sync_err), 64'(0));
        for (int k = 1; k <= 8; k++) send_pair(fl(k), fr(k), 1'b0);
        check("full_level", 64'(level), 64'(8));
        check("full_ovf", 64'(overflow), 64'(0));
        check("full_head", 64'({m_left, m_right}), 64'({fl(1), fr(1)}));
        drive(1'b1, 1'b0, fl(9), 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b1, fr(9), 1'b1, 1'b1, 1'b0);
        step();
        check("pushpop_level", 64'(level), 64'(8));
        check("pushpop_ovf", 64'(overflow), 64'(0));
        check("pushpop_head", 64'({m_left, m_right}), 64'({fl(2), fr(2)}));
        send_pair(fl(10), fr(10), 1'b0);
        check("ovf_level", 64'(level), 64'(8));
        check("ovf_flag", 64'(overflow), 64'(1));
        check("ovf_head", 64'({m_left, m_right}), 64'({fl(2), fr(2)}));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_valid", i), 64'(m_valid), 64'(1));
            check($sformatf("drain%0d_frame", i), 64'({m_left, m_right}), 64'({fl(i + 2), fr(i + 2)}));
            drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
            step();
        end
        check("drained_valid", 64'(m_valid), 64'(0));
        check("drained_level", 64'(level), 64'(0));

        // Clear with stored frames and both flags set
        drive(1'b1, 1'b1, 24'h777777, 1'b0, 1'b1, 1'b0);
        step();
        check("pre_clr_sync", 64'(sync_err), 64'(1));
        for (int k = 11; k <= 13; k++) send_pair(fl(k), fr(k), 1'b0);
        check("pre_clr_level", 64'(level), 64'(3));
        drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        step();
        check("clr_level", 64'(level), 64'(0));
        check("clr_valid", 64'(m_valid), 64'(0));
        check("clr_ovf", 64'(overflow), 64'(0));
        check("clr_sync2", 64'(sync_err), 64'(0));
        send_pair(24'hA5A5A5, 24'h5A5A5A, 1'b0);
        check("post_clr_valid", 64'(m_valid), 64'(1));
        check("post_clr_frame", 64'({m_left, m_right}), 64'({24'hA5A5A5, 24'h5A5A5A}));
        check("post_clr_level", 64'(level), 64'(1));

        // Async reset between edges with a left pending and a frame stored
        drive(1'b1, 1'b0, 24'hC0FFEE, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(m_valid), 64'(0));
        check("arst_level", 64'(level), 64'(0));
        check("arst_data", 64'({m_left, m_right}), 64'(0));
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 24'hBEEF01, 1'b0, 1'b1, 1'b0);
        step();
        check("arst_orphan_sync", 64'(sync_err), 64'(1));
        check("arst_orphan_valid", 64'(m_valid), 64'(0));
        check("arst_orphan_level", 64'(level), 64'(0));

        // Randomized run against the queue model
        drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        step();
        mq.delete();
        m_pend = 1'b0;
        m_hold = '0;
        m_sync = 1'b0;
        m_ovf  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic        r_sv, r_l, r_rdy, r_en, r_clr;
            logic [23:0] r_s;
            int          rdy_pct;
            rdy_pct = ((i / 500) % 2 == 1) ? 15 : 80;
            r_sv  = 1'($urandom_range(0, 1));
            r_l   = ($urandom_range(0, 9) < 8) ? m_pend : 1'($urandom_range(0, 1));
            r_s   = 24'($urandom);
            r_rdy = ($urandom_range(0, 99) < rdy_pct);
            r_en  = ($urandom_range(0, 31) != 0);
            r_clr = ($urandom_range(0, 199) == 0);
            model_cycle(r_sv, r_l, r_s, r_rdy, r_en, r_clr);
            drive(r_sv, r_l, r_s, r_rdy, r_en, r_clr);
            step();
            check("rnd_valid", 64'(m_valid), 64'(mq.size() != 0));
            check("rnd_level", 64'(level), 64'(mq.size()));
            check("rnd_sync", 64'(sync_err), 64'(m_sync));
            check("rnd_ovf", 64'(overflow), 64'(m_ovf));
            if (mq.size() != 0) begin
                check("rnd_frame", 64'({m_left, m_right}), 64'(mq[0]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
